data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Single-port, byte-addressable data memory serving the core's load/store path. Accepts one request at a time over a valid/ready request channel, performs byte/half/word reads with sign or zero extension and lane-masked writes, and returns the result over a valid/ready response channel. Sits between the core's execute stage (LOAD/STORE opcodes) and the 32-bit x DEPTH_WORDS data RAM.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; byte address space is 0 .. 4*DEPTH_WORDS-1
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_wdata  in  32  store data, low bits used for B/H
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  out  1  access faulted; no memory state changed

## Operation
- States: IDLE, ACCESS, ACCESS2 (only with split enabled), RESP.
- IDLE: req_ready=1. On req_valid&&req_ready latch we/addr/funct3/wdata, go ACCESS.
- ACCESS: read word addr[31:2]; compute error; for stores commit lane-masked write at the edge leaving ACCESS. Go RESP (or ACCESS2 for split access).
- RESP: rsp_valid=1, outputs stable until rsp_valid&&rsp_ready, then IDLE.
- Error conditions (rsp_err=1, rdata=0, no write): funct3 in {011,110,111}; store with funct3[2]=1; any byte of access at address >= 4*DEPTH_WORDS; misalignment (H with addr[0]=1, W with addr[1:0]!=0) when split disabled.
- Loads: lane = addr[1:0]; B/H sign-extend from bit 7/15, BU/HU zero-extend, W unchanged.
- Stores: B writes lane addr[1:0] with wdata[7:0]; H writes lanes addr[1]*2..+1 with wdata[15:0]; W writes all lanes. Other lanes unchanged.
- Address arithmetic is 32-bit unsigned; no wrap-around into low memory — overflowing addresses fault.

## Timing
- Reset values: state IDLE, req_ready=0 during reset cycle then 1, rsp_valid=0, rsp_rdata=0, rsp_err=0. RAM contents not reset.
- Aligned latency: accept at edge N, rsp_valid high from edge N+2. Split access: from edge N+3.
- Throughput: next request accepted earliest the cycle after response handshake (req_ready and rsp_valid never both high).
- rsp_valid held, rdata/err stable, while rsp_ready=0.
- Load following a store to same address sees the stored data.
- Reset asserted in ACCESS/ACCESS2 on the commit edge: write suppressed, no partial write, response dropped.

## Configuration
- DMEM_MISALIGN_SPLIT_EN defined: misaligned H/W split into two word accesses (ACCESS reads/writes word k, ACCESS2 word k+1); load result assembled little-endian from both; store writes upper lanes of k and lower lanes of k+1 atomically (both checked before either commit; if k+1 out of range, fault, no write).
- Undefined: misaligned H/W faults with rsp_err=1; ACCESS2 state absent.

## Structure
- Package dmem_pkg: funct3 width constants (B, H, W, BU, HU), state enum, default DEPTH_WORDS.
- Sub-module dmem_lane_align: combinational byte-lane extract/extend for loads and write-data/lane-mask generation for stores; used twice in split mode.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 -> rdata 0xDEADBEEF, err 0; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LHU 0x12 -> 0x0000DEAD.
- SB 0x55 to 0x11 over word 0xDEADBEEF at 0x10 -> LW 0x10 = 0xDEAD55EF; SH 0x1234 to 0x12 -> 0x123455EF.
- rsp_ready held 0 for 5 cycles after load -> rsp_valid and rdata stable, req_ready 0; handshake -> req_ready 1 next cycle.
- LW 0x3FE (DEPTH 256): split off -> err 1, rdata 0; split on -> rdata from bytes 0x3FE..0x401, 0x400 out of range -> err 1; SW there -> err, words 0xFC/0x3FC unchanged.
- Split on: SW 0xAABBCCDD to 0x21 -> LW 0x20 low byte preserved, bytes 0x21..0x24 = DD,CC,BB,AA; latency 3 cycles.
- Reset asserted during ACCESS of SW 0xFFFFFFFF to 0x40 (previously 0) -> after reset LW 0x40 = 0; funct3 011 request -> err 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared width codes, FSM state encodings and load-extension helper for data_mem_responder
package dmem_pkg;
  localparam int DMEM_DEPTH_WORDS = 256;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_ACCESS2 = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;
  function automatic logic [31:0] dmem_extend(input logic [31:0] raw, input logic [2:0] f3);
    return f3 == F3_B  ? {{24{raw[7]}}, raw[7:0]} :
           f3 == F3_H  ? {{16{raw[15]}}, raw[15:0]} :
           f3 == F3_BU ? {24'b0, raw[7:0]} :
           f3 == F3_HU ? {16'b0, raw[15:0]} : raw;
  endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: places one RAM word's bytes into load-result position and builds store lane mask/data
module dmem_lane_align (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic        hi,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rpart,
  output logic [3:0]  wmask,
  output logic [31:0] wword
);
  logic [63:0] rwin, wwin;
  logic [7:0] bmask, mwin;
  // hi selects the upper word of an 8-byte window that starts at the access word
  always_comb begin
    rwin = (hi ? {word, 32'b0} : {32'b0, word}) >> {lane, 3'b000};
    rpart = rwin[31:0];
    bmask = size == 2'b00 ? 8'h01 : size == 2'b01 ? 8'h03 : 8'h0f;
    mwin = bmask << lane;
    wwin = {32'b0, wdata} << {lane, 3'b000};
    wmask = hi ? mwin[7:4] : mwin[3:0];
    wword = hi ? wwin[63:32] : wwin[31:0];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready byte-addressable data RAM; define DMEM_MISALIGN_SPLIT_EN to split misaligned H/W accesses
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);
  logic [31:0] mem [DEPTH_WORDS];
  logic [1:0] state;
  logic we;
  logic [31:0] addr, wdata;
  logic [2:0] funct3;
  logic [AW-1:0] idx0, idx1;
  logic [1:0] size_m1;
  logic bad_f3, oob, misal, err, commit;
  logic [31:0] rpart0, rpart1, w0, w1;
  logic [3:0] m0, m1;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
  dmem_lane_align u_hi (
    .word(mem[idx1]), .lane(addr[1:0]), .hi(1'b1), .size(funct3[1:0]), .wdata(wdata),
    .rpart(rpart1), .wmask(m1), .wword(w1)
  );
`else
  localparam bit SPLIT = 1'b0;
  assign rpart1 = '0;
  assign m1 = '0;
  assign w1 = '0;
`endif
  dmem_lane_align u_lo (
    .word(mem[idx0]), .lane(addr[1:0]), .hi(1'b0), .size(funct3[1:0]), .wdata(wdata),
    .rpart(rpart0), .wmask(m0), .wword(w0)
  );
  // range check uses the last byte in 33 bits so high addresses cannot wrap into low memory
  always_comb begin
    idx0 = addr[AW+1:2];
    idx1 = idx0 + 1'b1;
    size_m1 = funct3[1:0] == 2'b00 ? 2'd0 : funct3[1:0] == 2'b01 ? 2'd1 : 2'd3;
    bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (we && funct3[2]);
    oob = ({1'b0, addr} + {31'b0, size_m1}) >= LIMIT;
    misal = (addr[1:0] & size_m1) != 2'b00;
    err = bad_f3 || oob || (misal && !SPLIT);
    commit = state == S_ACCESS2 || (state == S_ACCESS && !(SPLIT && misal));
  end
  assign rsp_valid = state == S_RESP;
  assign req_ready = state == S_IDLE && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        state <= S_ACCESS;
        we <= req_we;
        addr <= req_addr;
        funct3 <= req_funct3;
        wdata <= req_wdata;
      end else if (state == S_ACCESS) state <= commit ? S_RESP : S_ACCESS2;
      else if (state == S_ACCESS2) state <= S_RESP;
      else if (state == S_RESP && rsp_ready) state <= S_IDLE;
      if (commit) begin
        rsp_err <= err;
        rsp_rdata <= (err || we) ? '0 : dmem_extend(rpart0 | rpart1, funct3);
      end
    end
  end
  // both words of a split store are written on the same edge so reset can never leave half a store
  always_ff @(posedge clk) begin
    if (!reset && commit && we && !err)
      for (int b = 0; b < 4; b++) begin
        if (m0[b]) mem[idx0][8*b +: 8] <= w0[8*b +: 8];
        if (m1[b]) mem[idx1][8*b +: 8] <= w1[8*b +: 8];
      end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (both split and non-split builds)
module tb_data_mem_responder;
  localparam int DW = 256;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0] req_funct3 = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;
  exp_t sb[$];
  logic [7:0] mdl [int];
  int vectors = 0, errors = 0, lat = 0;

  data_mem_responder #(.DEPTH_WORDS(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic xfer(input logic we, input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input string nm, input int hold);
    exp_t e;
    int n;
    e.rdata = er;
    e.err = ee;
    e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_funct3 = f;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      vectors++;
      errors++;
      $display("FAIL %s: req_ready stayed %b, wanted 1", nm, req_ready);
      req_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    e = sb.pop_front();
    vectors++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL %s: rsp_valid timeout got %b want 1", e.name, rsp_valid);
      return;
    end
    if (rsp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h want %h", e.name, rsp_rdata, e.rdata);
    end
    vectors++;
    if (rsp_err !== e.err) begin
      errors++;
      $display("FAIL %s err: got %b want %b", e.name, rsp_err, e.err);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b req_ready=%b want 1/%h/%b/0",
                 e.name, i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  function automatic void model(input logic we, input logic [31:0] a, input logic [2:0] f,
                                input logic [31:0] wd, output logic [31:0] r, output logic e);
    int sz;
    sz = f[1:0] == 2'b00 ? 1 : f[1:0] == 2'b01 ? 2 : 4;
    e = (f == 3'b011 || f == 3'b110 || f == 3'b111) || (we && f[2]) ||
        (longint'(a) + sz - 1 >= 4 * DW) || (!SPLIT && (a % sz) != 0);
    r = '0;
    if (!e && we) for (int i = 0; i < sz; i++) mdl[int'(a) + i] = wd[8*i +: 8];
    if (!e && !we) begin
      for (int i = 0; i < sz; i++) r[8*i +: 8] = mdl[int'(a) + i];
      if (!f[2] && sz < 4 && r[8*sz-1]) for (int i = sz; i < 4; i++) r[8*i +: 8] = 8'hff;
    end
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b want 0/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_loads;
    xfer(1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0, "sw_10", 0);
    xfer(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0, "lw_10", 0);
    vectors++;
    if (lat != 2) begin
      errors++;
      $display("FAIL lat_aligned: got %0d want 2", lat);
    end
    xfer(0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 0, "lb_13", 0);
    xfer(0, 32'h13, 3'b100, 32'h0, 32'h000000DE, 0, "lbu_13", 0);
    xfer(0, 32'h12, 3'b101, 32'h0, 32'h0000DEAD, 0, "lhu_12", 0);
    xfer(0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 0, "lh_12", 0);
    xfer(0, 32'h10, 3'b000, 32'h0, 32'hFFFFFFEF, 0, "lb_10", 0);
  endtask

  task automatic test_stores;
    xfer(1, 32'h11, 3'b000, 32'hFFFFFF55, 32'h0, 0, "sb_11", 0);
    xfer(0, 32'h10, 3'b010, 32'h0, 32'hDEAD55EF, 0, "lw_after_sb", 0);
    xfer(1, 32'h12, 3'b001, 32'hFFFF1234, 32'h0, 0, "sh_12", 0);
    xfer(0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 0, "lw_after_sh", 0);
  endtask

  task automatic test_back_to_back;
    xfer(0, 32'h10, 3'b010, 32'h0, 32'h123455EF, 0, "backpressure", 5);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_boundary;
    xfer(1, 32'h3FC, 3'b010, 32'h22222222, 32'h0, 0, "sw_3fc", 0);
    xfer(1, 32'h0, 3'b010, 32'h33333333, 32'h0, 0, "sw_0", 0);
    xfer(0, 32'h3FE, 3'b010, 32'h0, 32'h0, 1, "lw_3fe", 0);
    xfer(1, 32'h3FE, 3'b010, 32'hFFFFFFFF, 32'h0, 1, "sw_3fe", 0);
    xfer(0, 32'h3FC, 3'b010, 32'h0, 32'h22222222, 0, "lw_3fc_kept", 0);
    xfer(0, 32'h0, 3'b010, 32'h0, 32'h33333333, 0, "lw_0_kept", 0);
    xfer(0, 32'h3FF, 3'b000, 32'h0, 32'h00000022, 0, "lb_3ff", 0);
    xfer(0, 32'h400, 3'b000, 32'h0, 32'h0, 1, "lb_400", 0);
    xfer(0, 32'hFFFFFFFC, 3'b010, 32'h0, 32'h0, 1, "lw_overflow", 0);
  endtask

  task automatic test_split;
    xfer(1, 32'h20, 3'b010, 32'h11223344, 32'h0, 0, "sw_20", 0);
    xfer(1, 32'h24, 3'b010, 32'h55667788, 32'h0, 0, "sw_24", 0);
    xfer(1, 32'h21, 3'b010, 32'hAABBCCDD, 32'h0, !SPLIT, "sw_21", 0);
    vectors++;
    if (lat != (SPLIT ? 3 : 2)) begin
      errors++;
      $display("FAIL lat_misaligned: got %0d want %0d", lat, SPLIT ? 3 : 2);
    end
    xfer(0, 32'h20, 3'b010, 32'h0, SPLIT ? 32'hBBCCDD44 : 32'h11223344, 0, "lw_20", 0);
    xfer(0, 32'h24, 3'b010, 32'h0, SPLIT ? 32'h556677AA : 32'h55667788, 0, "lw_24", 0);
    xfer(0, 32'h23, 3'b001, 32'h0, SPLIT ? 32'hFFFFAABB : 32'h0, !SPLIT, "lh_23", 0);
    xfer(0, 32'h22, 3'b010, 32'h0, SPLIT ? 32'h77AABBCC : 32'h0, !SPLIT, "lw_22", 0);
  endtask

  task automatic test_reset_access;
    xfer(1, 32'h40, 3'b010, 32'h0, 32'h0, 0, "sw_40_zero", 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h40;
    req_funct3 = 3'b010;
    req_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_access: rsp_valid=%b req_ready=%b want 0/0", rsp_valid, req_ready);
    end
    reset = 1'b0;
    xfer(0, 32'h40, 3'b010, 32'h0, 32'h0, 0, "lw_40_after_reset", 0);
    xfer(0, 32'h40, 3'b011, 32'h0, 32'h0, 1, "funct3_011", 0);
    xfer(1, 32'h40, 3'b100, 32'hFFFFFFFF, 32'h0, 1, "store_bu", 0);
    xfer(0, 32'h40, 3'b111, 32'h0, 32'h0, 1, "funct3_111", 0);
  endtask

  task automatic test_random;
    logic [31:0] r, a, d;
    logic e, w;
    logic [2:0] f;
    logic [2:0] codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      a = 32'h100 + 32'(4 * i);
      model(1'b1, a, 3'b010, d, r, e);
      xfer(1'b1, a, 3'b010, d, r, e, "rand_init", 0);
    end
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      f = codes[$urandom_range(0, 4)];
      a = 32'h100 + 32'($urandom_range(0, 56));
      d = $urandom;
      model(w, a, f, d, r, e);
      xfer(w, a, f, d, r, e, w ? "rand_store" : "rand_load", 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_back_to_back();
    test_boundary();
    test_split();
    test_reset_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
